// File: rtl/bless_inject_ctrl_pkg.sv
// Shared flit layout, port indices and FSM states for the BLESS local-injection controller.
// The link format is [PKTID6 FLITID2 TIME8 POS_X4 POS_Y4 DATA]; field offsets are relative to `WIDTH_DATA.
`ifndef WIDTH_DATA
`define WIDTH_DATA 32
`endif
`ifndef WIDTH_PORT
`define WIDTH_PORT (`WIDTH_DATA+24)
`endif

package bless_inject_ctrl_pkg;

  localparam int POS_Y_LSB  = `WIDTH_DATA;
  localparam int POS_Y_MSB  = `WIDTH_DATA + 3;
  localparam int POS_X_LSB  = `WIDTH_DATA + 4;
  localparam int POS_X_MSB  = `WIDTH_DATA + 7;
  localparam int TIME_LSB   = `WIDTH_DATA + 8;
  localparam int TIME_MSB   = `WIDTH_DATA + 15;
  localparam int FLITID_LSB = `WIDTH_DATA + 16;
  localparam int FLITID_MSB = `WIDTH_DATA + 17;
  localparam int PKTID_LSB  = `WIDTH_DATA + 18;
  localparam int PKTID_MSB  = `WIDTH_DATA + 23;

  localparam int PORT_W      = 0;
  localparam int PORT_E      = 1;
  localparam int PORT_S      = 2;
  localparam int PORT_N      = 3;
  localparam int PORT_LOCAL  = 4;
  localparam int PORT_BYPASS = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    STARVED = 2'd2
  } inj_state_e;

  // True when every network input carries a flit, so the router has no free slot for us.
  function automatic logic all_links_busy(input logic [3:0] link_valid);
    return link_valid[PORT_W] & link_valid[PORT_E] & link_valid[PORT_S] & link_valid[PORT_N];
  endfunction

endpackage

// File: rtl/bless_inject_ctrl_inj_fifo.sv
// Small synchronous FIFO holding PE flits until the router has a free input slot.
// Depth must be a power of two so the pointers wrap naturally.
module inj_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a flush only moves the pointers so stale words are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bless_inject_ctrl.sv
// Local-injection controller for the bufferless BLESS router: queues PE flits and injects the head
// whenever a network input is free. Optional injection throttling is enabled with BLESS_INJ_THROTTLE_EN.
module bless_inject_ctrl
  import bless_inject_ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int STARVE_TH = 16,
  parameter int QUOTA     = 4,
  parameter int WINDOW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [`WIDTH_PORT-1:0]   peFlit,
  input  logic                     peValid,
  output logic                     peReady,
  input  logic [3:0]               linkValid,
  output logic [`WIDTH_PORT-1:0]   dinLocal,
  output logic                     injValid,
  output logic                     starve,
  output logic [$clog2(DEPTH):0]   qCount
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_TH - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_TH < 1 || STARVE_TH > 255 ||
      QUOTA < 1 || QUOTA > 255 || WINDOW < 2 || WINDOW > 65536) begin : g_bad_cfg
    $error("bless_inject_ctrl: invalid parameter set");
  end

  logic [`WIDTH_PORT-1:0] head;
  logic [`WIDTH_PORT-1:0] inj_flit;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   inject;
  logic                   credit_ok;
  logic [7:0]             blk_cnt;
  inj_state_e             state;
  inj_state_e             state_next;

  assign peReady = !full;
  assign push    = peValid && peReady;
  assign inject  = !empty && !all_links_busy(linkValid) && credit_ok;

  inj_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (`WIDTH_PORT)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (inject),
    .din   (peFlit),
    .dout  (head),
    .count (qCount),
    .full  (full),
    .empty (empty)
  );

`ifdef BLESS_INJ_THROTTLE_EN
  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  localparam logic [7:0]  QUOTA_B  = 8'(QUOTA);

  logic [15:0] win_cnt;
  logic [7:0]  credit;
  logic        refill;

  assign refill    = (win_cnt == WIN_LAST);
  assign credit_ok = (credit != 8'd0);

  // An injection landing on the refill edge is charged to the new window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_cnt <= '0;
      credit  <= QUOTA_B;
    end else begin
      win_cnt <= refill ? 16'd0 : win_cnt + 16'd1;
      if (refill)
        credit <= inject ? QUOTA_B - 8'd1 : QUOTA_B;
      else if (inject)
        credit <= credit - 8'd1;
    end
  end
`else
  assign credit_ok = 1'b1;
`endif

  // The router expects a freshly injected flit to start with zero age.
  always_comb begin
    inj_flit                    = head;
    inj_flit[TIME_MSB:TIME_LSB] = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dinLocal <= '0;
      injValid <= 1'b0;
    end else begin
      dinLocal <= inject ? inj_flit : '0;
      injValid <= inject;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      blk_cnt <= '0;
    else if (empty || inject)
      blk_cnt <= '0;
    else if (blk_cnt != 8'hFF)
      blk_cnt <= blk_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (push) state_next = ARB;
      end
      ARB: begin
        if (inject)
          state_next = (qCount == 1 && !push) ? IDLE : ARB;
        else if (blk_cnt >= STARVE_LIM)
          state_next = STARVED;
      end
      STARVED: begin
        if (inject)
          state_next = (qCount == 1 && !push) ? IDLE : ARB;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    starve = (state == STARVED);
  end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Randomized, model-checked bench for bless_inject_ctrl plus directed scenarios with literal expectations.
// The reference model tracks the queue, per-head wait time and (with BLESS_INJ_THROTTLE_EN) window quota.
module tb_bless_inject_ctrl;

  localparam int DEPTH     = 4;
  localparam int STARVE_TH = 16;
  localparam int QUOTA     = 4;
  localparam int WINDOW    = 32;
  localparam int W         = `WIDTH_PORT;
  localparam int DW        = `WIDTH_DATA;

  logic                   clk;
  logic                   reset;
  logic [W-1:0]           peFlit;
  logic                   peValid;
  logic                   peReady;
  logic [3:0]             linkValid;
  logic [W-1:0]           dinLocal;
  logic                   injValid;
  logic                   starve;
  logic [$clog2(DEPTH):0] qCount;

  int checks   = 0;
  int failures = 0;
  bit checking = 0;

  bless_inject_ctrl #(
    .DEPTH     (DEPTH),
    .STARVE_TH (STARVE_TH),
    .QUOTA     (QUOTA),
    .WINDOW    (WINDOW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .peFlit    (peFlit),
    .peValid   (peValid),
    .peReady   (peReady),
    .linkValid (linkValid),
    .dinLocal  (dinLocal),
    .injValid  (injValid),
    .starve    (starve),
    .qCount    (qCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue contents, how long the current head has waited, quota used this window.
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_din;
  bit           exp_inj;
  bit           exp_starve;
  int           head_wait;
  int           m_cyc;
  int           m_win_inj;
  bit           m_inj;
  bit           m_push;
  bit           m_busy;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      exp_din    = '0;
      exp_inj    = 0;
      exp_starve = 0;
      head_wait  = 0;
      m_cyc      = 0;
      m_win_inj  = 0;
    end else begin
      m_busy = (mq.size() > 0);
      m_push = peValid && (mq.size() < DEPTH);
      m_inj  = m_busy && (linkValid != 4'b1111);
`ifdef BLESS_INJ_THROTTLE_EN
      m_inj  = m_inj && (m_win_inj < QUOTA);
`endif
      if (m_inj) begin
        exp_din = mq.pop_front();
        exp_din[DW+15:DW+8] = 8'd0;
        exp_inj    = 1;
        exp_starve = 0;
        head_wait  = 0;
      end else begin
        exp_din = '0;
        exp_inj = 0;
        if (m_busy) begin
          head_wait++;
          if (head_wait >= STARVE_TH) exp_starve = 1;
        end else begin
          head_wait = 0;
        end
      end
      if (m_push) mq.push_back(peFlit);
      if (m_cyc % WINDOW == WINDOW - 1) m_win_inj = m_inj ? 1 : 0;
      else                              m_win_inj += m_inj ? 1 : 0;
      m_cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("injValid",  64'(injValid), 64'(exp_inj));
    check("dinLocal",  64'(dinLocal), 64'(exp_din));
    check("peReady",   64'(peReady),  64'(mq.size() < DEPTH));
    check("qCount",    64'(qCount),   64'(mq.size()));
    check("starve",    64'(starve),   64'(exp_starve));
  endtask

  always @(negedge clk) begin
    if (checking) checkOutput();
  end

  task automatic applyStimulus(input bit valid, input logic [W-1:0] flit, input logic [3:0] links);
    @(negedge clk);
    peValid   = valid;
    peFlit    = flit;
    linkValid = links;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset   = 1'b0;
    peValid = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
  endtask

  function automatic logic [W-1:0] mk_flit(input int pkt, input int fid, input int tm,
                                           input int x, input int y, input int data);
    return {6'(pkt), 2'(fid), 8'(tm), 4'(x), 4'(y), DW'(data)};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mode;
    reset     = 1'b0;
    peValid   = 1'b0;
    peFlit    = '0;
    linkValid = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1;
    check("rst_dinLocal", 64'(dinLocal), 64'd0);
    check("rst_injValid", 64'(injValid), 64'd0);
    check("rst_peReady",  64'(peReady),  64'd1);
    check("rst_qCount",   64'(qCount),   64'd0);
    check("rst_starve",   64'(starve),   64'd0);
    reset = 1'b1;

    // Single flit: injected two cycles after the push with its age cleared.
    applyStimulus(1, mk_flit(5, 0, 9, 0, 3, 'hF), 4'b0101);
    applyStimulus(0, '0, 4'b0101);
    check("single_q1",  64'(qCount),   64'd1);
    check("single_pre", 64'(injValid), 64'd0);
    @(negedge clk);
    check("single_inj", 64'(injValid), 64'd1);
    check("single_din", 64'(dinLocal), 64'(mk_flit(5, 0, 0, 0, 3, 'hF)));
    check("single_q0",  64'(qCount),   64'd0);

    // Full queue under total link occupancy, then drain in order.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, mk_flit(i + 1, i, 7, i, 2, 'hA0 + i), 4'b1111);
    applyStimulus(0, '0, 4'b1111);
    check("full_q",     64'(qCount),  64'd4);
    check("full_ready", 64'(peReady), 64'd0);
    applyStimulus(0, '0, 4'b0111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_inj", 64'(injValid), 64'd1);
      check("drain_din", 64'(dinLocal), 64'(mk_flit(i + 1, i, 0, i, 2, 'hA0 + i)));
    end
    @(negedge clk);
    check("drain_done", 64'(injValid), 64'd0);

    // Starvation after 16 blocked cycles, cleared once the flit gets out.
    doReset();
    applyStimulus(1, mk_flit(9, 1, 200, 1, 1, 'h55), 4'b1111);
    applyStimulus(0, '0, 4'b1111);
    repeat (15) @(negedge clk);
    check("starve_15", 64'(starve), 64'd0);
    @(negedge clk);
    check("starve_16", 64'(starve), 64'd1);
    repeat (4) @(negedge clk);
    applyStimulus(0, '0, 4'b0000);
    @(negedge clk);
    check("starve_inj", 64'(injValid), 64'd1);
    check("starve_clr", 64'(starve),   64'd0);
    check("starve_din", 64'(dinLocal), 64'(mk_flit(9, 1, 0, 1, 1, 'h55)));

    // Simultaneous push and pop keeps occupancy; a mid-stream reset discards the queue.
    doReset();
    applyStimulus(1, mk_flit(1, 0, 3, 0, 0, 1), 4'b1111);
    applyStimulus(1, mk_flit(2, 0, 3, 0, 0, 2), 4'b1111);
    applyStimulus(1, mk_flit(3, 0, 3, 0, 0, 3), 4'b0000);
    applyStimulus(0, '0, 4'b1111);
    check("pushpop_q",   64'(qCount),   64'd2);
    check("pushpop_inj", 64'(injValid), 64'd1);
    doReset();
    applyStimulus(0, '0, 4'b0000);
    repeat (4) @(negedge clk);
    check("flush_q",   64'(qCount),   64'd0);
    check("flush_inj", 64'(injValid), 64'd0);

    // Randomized traffic in phases of free, congested and mixed links.
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 64 == 0) mode = int'($urandom_range(0, 2));
      reset   = ($urandom_range(0, 299) != 0);
      peValid = $urandom_range(0, 1) == 1;
      peFlit  = W'({$urandom, $urandom});
      case (mode)
        0:       linkValid = 4'($urandom);
        1:       linkValid = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b1111;
        default: linkValid = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'b0000;
      endcase
    end
    @(negedge clk);
    reset    = 1'b1;
    peValid  = 1'b0;
    repeat (2) @(negedge clk);
    checking = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
